in_switch: RTL and testbench

- Splits one AXI-Stream input into two AXI-Stream outputs by beat count; the input-side counterpart of the two-into-one output merge.
- Alternates phases: `len_0` beats go to port 0, then `len_1` beats go to port 1, then repeat.
- Each output has a one-deep register stage, so the input is decoupled from each downstream consumer.
- Sits in front of the two systolic data paths and hands each path its share of the incoming data stream.

---
 rtl/in_switch_pkg.sv | 17 +
 rtl/in_switch_if.sv | 37 +++
 rtl/in_switch_axis_reg_slice.sv | 46 ++++
 rtl/in_switch.sv | 100 ++++++++++
 tb/tb_in_switch.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/in_switch_pkg.sv
// Shared definitions for the stream switch and its output-merge counterpart.
// Holds the default widths and the phase encoding.
package in_switch_pkg;

  localparam int DWIDTH_DEF = 128;
  localparam int CWIDTH_DEF = 16;

  typedef enum logic {
    PH_0 = 1'b0,
    PH_1 = 1'b1
  } phase_e;

  function automatic phase_e phase_flip(input phase_e p);
    return (p == PH_0) ? PH_1 : PH_0;
  endfunction

endpackage

// File: rtl/in_switch_if.sv
// AXI-Stream bundle for the switch: one slave input and two master outputs.
// The slave modport is the switch's view; master is the surrounding environment.
interface in_switch_if
  import in_switch_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
);

  logic [DWIDTH-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DWIDTH-1:0] m_axis_tdata_0;
  logic              m_axis_tvalid_0;
  logic              m_axis_tready_0;
  logic [DWIDTH-1:0] m_axis_tdata_1;
  logic              m_axis_tvalid_1;
  logic              m_axis_tready_1;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata_0, m_axis_tvalid_0,
    input  m_axis_tready_0,
    output m_axis_tdata_1, m_axis_tvalid_1,
    input  m_axis_tready_1
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata_0, m_axis_tvalid_0,
    output m_axis_tready_0,
    input  m_axis_tdata_1, m_axis_tvalid_1,
    output m_axis_tready_1
  );

endinterface

// File: rtl/in_switch_axis_reg_slice.sv
// One-deep AXI-Stream output register. space_o tells the feeder a beat can be
// loaded this cycle (empty, or the current beat leaves on this edge).
module axis_reg_slice
  import in_switch_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              tready_i,
  output logic [DWIDTH-1:0] tdata_o,
  output logic              tvalid_o,
  output logic              space_o
);

  logic [DWIDTH-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;

  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    if (load_i) begin
      tdata_d  = data_i;
      tvalid_d = 1'b1;
    end else if (tready_i) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign tdata_o  = tdata_q;
  assign tvalid_o = tvalid_q;
  assign space_o  = ~tvalid_q | tready_i;

endmodule

// File: rtl/in_switch.sv
// Splits one AXI-Stream into two by beat count: len_0 beats to port 0, then
// len_1 beats to port 1, repeating. Each output goes through a register slice.
module in_switch
  import in_switch_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int CWIDTH = CWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CWIDTH-1:0] cfg_len_0,
  input  logic [CWIDTH-1:0] cfg_len_1,
  in_switch_if.slave        axis,
  output logic              sel
);

  phase_e            sel_q, sel_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  logic [CWIDTH-1:0] len_0_q, len_0_d;
  logic [CWIDTH-1:0] len_1_q, len_1_d;
  logic              load_q;

  logic [CWIDTH-1:0] len_cur, len_oth;
  logic              space_0, space_1, space_cur;
  logic              stall, skip, s_tready, accept, last, load_len;
  logic              load_0, load_1;

  always_comb begin
    len_cur   = (sel_q == PH_0) ? len_0_q : len_1_q;
    len_oth   = (sel_q == PH_0) ? len_1_q : len_0_q;
    space_cur = (sel_q == PH_0) ? space_0 : space_1;
    stall     = (len_0_q == '0) && (len_1_q == '0);
    skip      = (len_cur == '0) && (len_oth != '0);
    // An empty current phase (stall or pending skip) must never take a beat.
    s_tready  = (len_cur != '0) && space_cur;
    accept    = axis.s_axis_tvalid && s_tready;
    last      = accept && (cnt_q == len_cur - CWIDTH'(1));
    load_len  = load_q || stall || skip || last;
    load_0    = accept && (sel_q == PH_0);
    load_1    = accept && (sel_q == PH_1);
  end

  always_comb begin
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    len_0_d = len_0_q;
    len_1_d = len_1_q;
    if (accept) begin
      cnt_d = last ? '0 : cnt_q + CWIDTH'(1);
      if (last && (len_oth != '0)) sel_d = phase_flip(sel_q);
    end
    if (skip) sel_d = phase_flip(sel_q);
    if (load_len) begin
      len_0_d = cfg_len_0;
      len_1_d = cfg_len_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= PH_0;
      cnt_q   <= '0;
      len_0_q <= '0;
      len_1_q <= '0;
      load_q  <= 1'b1;
    end else begin
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      len_0_q <= len_0_d;
      len_1_q <= len_1_d;
      load_q  <= 1'b0;
    end
  end

  axis_reg_slice #(.DWIDTH(DWIDTH)) u_slice_0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_0),
    .data_i   (axis.s_axis_tdata),
    .tready_i (axis.m_axis_tready_0),
    .tdata_o  (axis.m_axis_tdata_0),
    .tvalid_o (axis.m_axis_tvalid_0),
    .space_o  (space_0)
  );

  axis_reg_slice #(.DWIDTH(DWIDTH)) u_slice_1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_1),
    .data_i   (axis.s_axis_tdata),
    .tready_i (axis.m_axis_tready_1),
    .tdata_o  (axis.m_axis_tdata_1),
    .tvalid_o (axis.m_axis_tvalid_1),
    .space_o  (space_1)
  );

  assign axis.s_axis_tready = s_tready;
  assign sel                = logic'(sel_q);

endmodule

// File: tb/tb_in_switch.sv
// Scoreboard bench for in_switch: the driver queues each accepted beat for its
// expected port, an independent monitor pops and compares on output handshakes.
module tb_in_switch;
  localparam int DW = 128;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] cfg0 = '0, cfg1 = '0;
  logic          sel;

  in_switch_if #(.DWIDTH(DW)) bus ();

  in_switch #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_len_0 (cfg0),
    .cfg_len_1 (cfg1),
    .axis      (bus),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int seq = 1;
  bit rnd_valid = 1'b0;
  bit rnd_stop = 1'b0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int port_q[$];

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every output handshake must match the oldest queued beat of that port.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.m_axis_tvalid_0 && bus.m_axis_tready_0) begin
          if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL port0_unexpected: got %0h expected no beat", bus.m_axis_tdata_0);
          end else chk("port0_data", bus.m_axis_tdata_0, q0.pop_front());
        end
        if (bus.m_axis_tvalid_1 && bus.m_axis_tready_1) begin
          if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL port1_unexpected: got %0h expected no beat", bus.m_axis_tdata_1);
          end else chk("port1_data", bus.m_axis_tdata_1, q1.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    q0.delete(); q1.delete(); port_q.delete();
    acc_cnt = 0;
    #2;
    chk("rst_tvalid0", bus.m_axis_tvalid_0, 0);
    chk("rst_tvalid1", bus.m_axis_tvalid_1, 0);
    chk("rst_tdata0", bus.m_axis_tdata_0, 0);
    chk("rst_sel", sel, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send_beats(input int n);
    int i = 0;
    int guard = 0;
    int p = 0;
    bit acc;
    logic [DW-1:0] d;
    while (i < n && guard < 20000) begin
      d = {4{32'(seq)}};
      bus.s_axis_tdata  = d;
      bus.s_axis_tvalid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = bus.s_axis_tvalid && bus.s_axis_tready;
      if (acc) begin
        p = port_q.pop_front();
        chk("sel_at_accept", sel, p);
        if (p == 0) q0.push_back(d); else q1.push_back(d);
      end
      @(posedge clk); #1;
      if (acc) begin
        chk("latency_tvalid", (p == 0) ? bus.m_axis_tvalid_0 : bus.m_axis_tvalid_1, 1);
        chk("latency_tdata", (p == 0) ? bus.m_axis_tdata_0 : bus.m_axis_tdata_1, d);
        seq++; i++; acc_cnt++;
      end
      guard++;
    end
    bus.s_axis_tvalid = 1'b0;
    if (guard >= 20000) begin
      errors++; checks++;
      $display("FAIL send_timeout: got %0d beats expected %0d", i, n);
    end
  endtask

  task automatic drain();
    bus.m_axis_tready_0 = 1'b1;
    bus.m_axis_tready_1 = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
  endtask

  task automatic push_ports(input int a, input int b, input int n);
    for (int k = 0; k < n; k++) port_q.push_back(((k % (a + b)) >= a) ? 1 : 0);
  endtask

  initial begin
    bus.s_axis_tdata = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready_0 = 1'b1;
    bus.m_axis_tready_1 = 1'b1;
    @(posedge clk); #1;

    // 3/2 continuous traffic
    cfg0 = 3; cfg1 = 2;
    do_reset();
    chk("tready_first_cycle", bus.s_axis_tready, 0);
    push_ports(3, 2, 8);
    send_beats(8);
    drain();

    // 4/4 with port-0 backpressure
    cfg0 = 4; cfg1 = 4;
    do_reset();
    push_ports(4, 4, 12);
    fork
      send_beats(12);
      begin
        int g = 0;
        while (acc_cnt < 2 && g < 100) begin @(posedge clk); #2; g++; end
        bus.m_axis_tready_0 = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_tready_low", bus.s_axis_tready, 0);
          chk("bp_port1_idle", bus.m_axis_tvalid_1, 0);
          @(posedge clk); #2;
        end
        bus.m_axis_tready_0 = 1'b1;
      end
    join
    drain();

    // 0/3 skip, then 0/0 stall, then 2/2 resume
    cfg0 = 0; cfg1 = 3;
    do_reset();
    push_ports(0, 3, 6);
    send_beats(6);
    drain();
    cfg0 = 0; cfg1 = 0;
    do_reset();
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata = '1;
    repeat (4) begin
      @(negedge clk);
      chk("stall_tready", bus.s_axis_tready, 0);
      chk("stall_sel", sel, 0);
      @(posedge clk); #1;
    end
    bus.s_axis_tvalid = 1'b0;
    cfg0 = 2; cfg1 = 2;
    @(negedge clk);
    chk("resume_not_yet", bus.s_axis_tready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("resume_tready", bus.s_axis_tready, 1);
    @(posedge clk); #1;
    push_ports(2, 2, 4);
    send_beats(4);
    drain();

    // cfg_len_0 changes 3 -> 1 mid phase
    cfg0 = 3; cfg1 = 2;
    do_reset();
    port_q = '{0, 0, 0, 1, 1, 0, 1, 1, 0};
    fork
      send_beats(9);
      begin
        int g = 0;
        while (acc_cnt < 1 && g < 100) begin @(posedge clk); #2; g++; end
        cfg0 = 1;
      end
    join
    drain();

    // random valid/ready, 5/7, 1000 beats
    cfg0 = 5; cfg1 = 7;
    do_reset();
    push_ports(5, 7, 1000);
    rnd_valid = 1'b1;
    rnd_stop = 1'b0;
    fork
      begin send_beats(1000); rnd_stop = 1'b1; end
      begin
        while (!rnd_stop) begin
          bus.m_axis_tready_0 = 1'($urandom_range(0, 1));
          bus.m_axis_tready_1 = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    rnd_valid = 1'b0;
    drain();

    // async reset with both outputs holding beats
    cfg0 = 1; cfg1 = 1;
    do_reset();
    bus.m_axis_tready_0 = 1'b0;
    bus.m_axis_tready_1 = 1'b0;
    port_q = '{0, 1};
    send_beats(2);
    chk("pre_rst_tvalid0", bus.m_axis_tvalid_0, 1);
    chk("pre_rst_tvalid1", bus.m_axis_tvalid_1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_tvalid0", bus.m_axis_tvalid_0, 0);
    chk("async_tvalid1", bus.m_axis_tvalid_1, 0);
    chk("async_tdata1", bus.m_axis_tdata_1, 0);
    chk("async_sel", sel, 0);
    q0.delete(); q1.delete(); port_q.delete();
    @(posedge clk); #1;
    cfg0 = 2; cfg1 = 2;
    rst_n = 1'b1;
    bus.m_axis_tready_0 = 1'b1;
    bus.m_axis_tready_1 = 1'b1;
    port_q = '{0, 0, 1};
    send_beats(3);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
